div_hilo_sched: RTL and testbench

Sequencing controller for the execute-stage arithmetic unit in the pipelined CPU. It decodes the EX-stage R-type function code and selects the result source: ALU, shifter, HI or LO. It runs the multi-cycle DIVU operation by issuing the start pulse, driving the cycle counter and generating the one-cycle HI/LO write enable. It stalls the pipeline while a later DIVU, MFHI or MFLO would hit a busy divider or stale HI/LO.

---
 rtl/div_hilo_sched.sv | 77 +++++++
 tb/tb_div_hilo_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/div_hilo_sched.sv
// div_hilo_sched: EX-stage result-select decode and multi-cycle DIVU sequencer with HI/LO hazard stall
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   ex_valid     EX stage holds a valid instruction
//   ex_alu_op    ALUOp of the EX instruction (2'b10 = R-type)
//   ex_funct     function field of the EX instruction
//   divisor_zero EX-stage divisor is zero, sampled at DIVU issue
//   stall        hold IF/ID/EX (combinational)
//   div_start    one-cycle divider operand load
//   div_run      divider iterating
//   div_cnt      divider iteration index
//   hilo_we      one-cycle HI/LO write
//   mux_sel      00 ALU, 01 shifter, 10 HI, 11 LO (combinational)
//   busy         sequencer not idle
//   div_zero     sticky zero-divisor flag of the last DIVU
module div_hilo_sched #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [1:0]       ex_alu_op,
  input  logic [5:0]       ex_funct,
  input  logic             divisor_zero,
  output logic             stall,
  output logic             div_start,
  output logic             div_run,
  output logic [CNT_W-1:0] div_cnt,
  output logic             hilo_we,
  output logic [1:0]       mux_sel,
  output logic             busy,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2} state_t;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);
  state_t state;
  logic rtype, is_divu, is_mfhi, is_mflo, is_sll;
  assign rtype     = ex_valid && ex_alu_op == 2'b10;
  assign is_divu   = rtype && ex_funct == F_DIVU;
  assign is_mfhi   = rtype && ex_funct == F_MFHI;
  assign is_mflo   = rtype && ex_funct == F_MFLO;
  assign is_sll    = rtype && ex_funct == F_SLL;
  assign busy      = state != IDLE;
  assign div_start = state == IDLE && is_divu;
  assign div_run   = state == RUN;
  assign hilo_we   = state == WB;
  // Any HI/LO consumer or a new DIVU must wait until the divider has written back.
  assign stall     = (is_divu || is_mfhi || is_mflo) && busy;
  assign mux_sel   = is_sll ? 2'b01 : is_mfhi ? 2'b10 : is_mflo ? 2'b11 : 2'b00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_divu) begin
          div_zero <= divisor_zero;
          div_cnt  <= '0;
          // A zero divisor has a trivial result, so iteration is skipped.
          state    <= divisor_zero ? WB : RUN;
        end
        RUN: if (div_cnt == LAST) begin
          state   <= WB;
          div_cnt <= '0;
        end else div_cnt <= div_cnt + CNT_W'(1);
        WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_hilo_sched.sv
// tb_div_hilo_sched: scoreboard bench for div_hilo_sched with directed per-cycle expectations
module tb_div_hilo_sched;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] ADD  = 6'b100000;
  typedef struct packed {
    logic       stall;
    logic       start;
    logic       run;
    logic [6:0] cnt;
    logic       we;
    logic [1:0] mux;
    logic       busy;
    logic       dz;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ex_valid = 1'b0;
  logic [1:0] ex_alu_op = 2'b00;
  logic [5:0] ex_funct = 6'd0;
  logic divisor_zero = 1'b0;
  logic stall, div_start, div_run, hilo_we, busy, div_zero;
  logic [6:0] div_cnt;
  logic [1:0] mux_sel;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  string name_q[$];
  div_hilo_sched #(.DIV_CYCLES(32), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_funct(ex_funct), .divisor_zero(divisor_zero), .stall(stall),
    .div_start(div_start), .div_run(div_run), .div_cnt(div_cnt),
    .hilo_we(hilo_we), .mux_sel(mux_sel), .busy(busy), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic st, sa, ru, input int c, input logic we,
                              input logic [1:0] m, input logic b, z);
    exp_t e;
    e.stall = st;
    e.start = sa;
    e.run = ru;
    e.cnt = 7'(c);
    e.we = we;
    e.mux = m;
    e.busy = b;
    e.dz = z;
    return e;
  endfunction
  task automatic drive(input logic r, v, input logic [1:0] a, input logic [5:0] f,
                       input logic z, input exp_t e, input string n);
    @(posedge clk);
    #1;
    reset = r;
    ex_valid = v;
    ex_alu_op = a;
    ex_funct = f;
    divisor_zero = z;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall, div_start, div_run, div_cnt, hilo_we, mux_sel, busy, div_zero};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s t=%0t got stall=%b start=%b run=%b cnt=%0d we=%b mux=%b busy=%b dz=%b expected stall=%b start=%b run=%b cnt=%0d we=%b mux=%b busy=%b dz=%b",
                 n, $time, a.stall, a.start, a.run, a.cnt, a.we, a.mux, a.busy, a.dz,
                 e.stall, e.start, e.run, e.cnt, e.we, e.mux, e.busy, e.dz);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 3; i++) drive(0, 1, 2'b10, ADD, 0, mk(0,0,0,0,0,2'b00,0,0), "reset_idle");
    for (int i = 0; i < 2; i++) drive(1, 1, 2'b10, ADD, 0, mk(0,0,0,0,0,2'b00,0,0), "idle_add");
    drive(1, 1, 2'b10, DIVU, 0, mk(0,1,0,0,0,2'b00,0,0), "divu_issue");
    for (int i = 0; i < 32; i++)
      if (i == 5) drive(1, 1, 2'b10, ADD, 0, mk(0,0,1,i,0,2'b00,1,0), "add_while_busy");
      else drive(1, 1, 2'b10, MFHI, 0, mk(1,0,1,i,0,2'b10,1,0), "mfhi_run_stall");
    drive(1, 1, 2'b10, MFHI, 0, mk(1,0,0,0,1,2'b10,1,0), "mfhi_wb_stall");
    drive(1, 1, 2'b10, MFHI, 0, mk(0,0,0,0,0,2'b10,0,0), "mfhi_release");
    drive(1, 1, 2'b10, DIVU, 1, mk(0,1,0,0,0,2'b00,0,0), "divu_zero_issue");
    drive(1, 0, 2'b10, DIVU, 0, mk(0,0,0,0,1,2'b00,1,1), "zero_wb_invalid");
    drive(1, 1, 2'b10, ADD, 0, mk(0,0,0,0,0,2'b00,0,1), "zero_back_idle");
    drive(1, 1, 2'b10, MFLO, 0, mk(0,0,0,0,0,2'b11,0,1), "mflo_keeps_dz");
    drive(1, 1, 2'b00, DIVU, 0, mk(0,0,0,0,0,2'b00,0,1), "non_rtype_divu");
    drive(1, 1, 2'b10, ADD, 0, mk(0,0,0,0,0,2'b00,0,1), "non_rtype_no_issue");
    drive(1, 1, 2'b10, DIVU, 0, mk(0,1,0,0,0,2'b00,0,1), "divu_after_zero");
    for (int i = 0; i < 32; i++) drive(1, 1, 2'b10, DIVU, 0, mk(1,0,1,i,0,2'b00,1,0), "b2b_run_stall");
    drive(1, 1, 2'b10, DIVU, 0, mk(1,0,0,0,1,2'b00,1,0), "b2b_wb_stall");
    drive(1, 1, 2'b10, DIVU, 0, mk(0,1,0,0,0,2'b00,0,0), "b2b_issue");
    for (int i = 0; i < 15; i++) drive(1, 1, 2'b10, MFLO, 0, mk(1,0,1,i,0,2'b11,1,0), "mflo_run_stall");
    drive(0, 1, 2'b10, MFLO, 0, mk(0,0,0,0,0,2'b11,0,0), "reset_mid_run");
    drive(0, 1, 2'b10, MFLO, 0, mk(0,0,0,0,0,2'b11,0,0), "reset_hold");
    for (int i = 0; i < 40; i++) drive(1, 1, 2'b10, ADD, 0, mk(0,0,0,0,0,2'b00,0,0), "no_we_after_reset");
    drive(1, 1, 2'b10, DIVU, 0, mk(0,1,0,0,0,2'b00,0,0), "divu_after_reset");
    for (int i = 0; i < 3; i++) drive(1, 1, 2'b10, ADD, 0, mk(0,0,1,i,0,2'b00,1,0), "restart_cnt");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
